// File: rtl/qkd_tx_pkg.sv
// Shared definitions for the transmitter data path.
//   - 3-bit symbol codes produced from the pulse generator's one-hot laser select
//   - bit positions of each laser inside the 6-bit one-hot word
//   - 32-bit logging word layout: ten 3-bit symbols in bits [29:0], 2-bit sequence tag in [31:30]
//   - encode_pulses(): one-hot laser select -> symbol code
package qkd_tx_pkg;

    localparam int PULSE_W       = 6;
    localparam int SYM_W         = 3;
    localparam int SYMS_PER_WORD = 10;
    localparam int WORD_W        = 32;
    localparam int SEQ_W         = 2;
    localparam int SEQ_LSB       = 30;

    // One-hot bit index of each laser in the pulse word
    localparam int BIT_SIG_R = 0;
    localparam int BIT_SIG_L = 1;
    localparam int BIT_SIG_H = 2;
    localparam int BIT_DEC_R = 3;
    localparam int BIT_DEC_L = 4;
    localparam int BIT_DEC_H = 5;

    // Symbol codes
    localparam logic [SYM_W-1:0] SYM_VAC     = 3'd0;
    localparam logic [SYM_W-1:0] SYM_SIG_R   = 3'd1;
    localparam logic [SYM_W-1:0] SYM_SIG_L   = 3'd2;
    localparam logic [SYM_W-1:0] SYM_SIG_H   = 3'd3;
    localparam logic [SYM_W-1:0] SYM_DEC_R   = 3'd4;
    localparam logic [SYM_W-1:0] SYM_DEC_L   = 3'd5;
    localparam logic [SYM_W-1:0] SYM_DEC_H   = 3'd6;
    localparam logic [SYM_W-1:0] SYM_INVALID = 3'd7;
    // Unused slots of a flushed word share the invalid code
    localparam logic [SYM_W-1:0] SYM_PAD     = 3'd7;

    // Anything that is neither all-zero nor exactly one-hot is reported as invalid
    function automatic logic [SYM_W-1:0] encode_pulses(input logic [PULSE_W-1:0] p);
        logic [SYM_W-1:0] c;
        c = SYM_INVALID;
        if (p == '0)                           c = SYM_VAC;
        else if (p == (6'd1 << BIT_SIG_R))     c = SYM_SIG_R;
        else if (p == (6'd1 << BIT_SIG_L))     c = SYM_SIG_L;
        else if (p == (6'd1 << BIT_SIG_H))     c = SYM_SIG_H;
        else if (p == (6'd1 << BIT_DEC_R))     c = SYM_DEC_R;
        else if (p == (6'd1 << BIT_DEC_L))     c = SYM_DEC_L;
        else if (p == (6'd1 << BIT_DEC_H))     c = SYM_DEC_H;
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   push, wdata  : write request and data; written only when push_ok
//   pop          : read request; ignored while empty
//   rdata        : head-of-FIFO word, valid in the same cycle as !empty (0 when empty)
//   empty        : no words stored
//   count        : words stored, 0..DEPTH
//   push_ok      : the push of this cycle is accepted (not full, or a pop frees a slot)
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_MAX);
    assign pop_ok  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push lands in
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_q;
    // Gate the head word so the output reads zero after reset instead of stale RAM
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset so it can map onto RAM resources
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/symbol_packer.sv
// Encodes the pulse generator's one-hot laser select into 3-bit symbols, packs
// ten symbols plus a 2-bit sequence tag per 32-bit word and streams the words
// out of a small FIFO over a valid/ready interface.
//   clk, reset_n    : clock, asynchronous active-low reset
//   enable          : sample pulses on this edge
//   pulses          : one-hot laser select (all-zero = vacuum)
//   flush           : emit the partially filled word, padded with code 7
//   out_data/valid  : head-of-FIFO word / FIFO not empty
//   out_ready       : sink accepts the head word
//   overflow        : sticky, a completed word was dropped on a full FIFO
//   clear_overflow  : clears overflow (a drop on the same edge wins)
//   fill_level      : words currently buffered
module symbol_packer
    import qkd_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [PULSE_W-1:0]            pulses,
    input  logic                          flush,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam logic [3:0] LAST_SLOT = 4'(SYMS_PER_WORD - 1);

    logic [SYM_W-1:0] code;
    logic [SYMS_PER_WORD-1:0][SYM_W-1:0] slots_q, slots_d;
    logic [SYMS_PER_WORD-1:0][SYM_W-1:0] sampled_slots;
    logic [SYMS_PER_WORD-1:0][SYM_W-1:0] word_slots;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        fill_n;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic              complete;
    logic              do_flush;
    logic              word_push;
    logic              push_ok;
    logic              fifo_empty;
    logic              pop;
    logic [WORD_W-1:0] word;

    assign code = encode_pulses(pulses);

    // Number of symbols the word holds once this cycle's sample is counted
    assign fill_n    = cnt_q + {3'b000, enable};
    assign complete  = enable && (cnt_q == LAST_SLOT);
    // A flush on the completing edge adds nothing: the word goes out anyway
    assign do_flush  = flush && !complete && (fill_n != 4'd0);
    assign word_push = complete || do_flush;

    genvar gi;
    generate
        for (gi = 0; gi < SYMS_PER_WORD; gi++) begin : g_slot
            assign sampled_slots[gi] = (enable && (cnt_q == 4'(gi))) ? code : slots_q[gi];
            // Slots beyond the symbols collected so far only matter on a flush
            assign word_slots[gi]    = (4'(gi) < fill_n) ? sampled_slots[gi] : SYM_PAD;
        end
    endgenerate

    always_comb begin
        word = '0;
        word[SYMS_PER_WORD*SYM_W-1:0] = word_slots;
        word[SEQ_LSB +: SEQ_W]        = seq_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        slots_d    = slots_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        if (word_push) begin
            // seq advances even on a drop so the loss shows up as a tag gap
            cnt_d   = 4'd0;
            slots_d = '0;
            seq_d   = seq_q + 2'd1;
        end else if (enable) begin
            cnt_d   = cnt_q + 4'd1;
            slots_d = sampled_slots;
        end
        if (word_push && !push_ok) overflow_d = 1'b1;
        else if (clear_overflow)   overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            slots_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            slots_q    <= slots_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    assign pop       = !fifo_empty && out_ready;
    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (word_push),
        .wdata   (word),
        .pop     (pop),
        .rdata   (out_data),
        .empty   (fifo_empty),
        .count   (fill_level),
        .push_ok (push_ok)
    );

endmodule

// File: tb/tb_symbol_packer.sv
module tb_symbol_packer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [5:0]  pulses = '0;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [4:0]  fill_level;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    symbol_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .pulses         (pulses),
        .flush          (flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .fill_level     (fill_level)
    );

    // Record every word the sink accepts; inputs only change just after posedge
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic cyc(input logic en, input logic [5:0] p, input logic fl);
        enable = en;
        pulses = p;
        flush  = fl;
        @(posedge clk);
        #1;
        enable = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        got_q.delete();
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    logic [5:0]  vec1 [10] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000,
                              6'b100000, 6'b000000, 6'b000011, 6'b000001, 6'b000001};
    logic [5:0]  vec_tog [10] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000,
                                 6'b100000, 6'b000000, 6'b000001, 6'b000010, 6'b000100};
    logic [31:0] exp2 [3] = '{32'h0000_0000, 32'h4000_0000, 32'hBFFF_8000};

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);

        // Full word: codes 1,2,3,4,5,6,0,7,1,1
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, vec1[i], 1'b0);
            if (i == 8) check("w1_valid_before", 32'(out_valid), 32'd0);
        end
        check("w1_valid", 32'(out_valid), 32'd1);
        check("w1_data", out_data, 32'h09E3_58D1);
        check("w1_fill", 32'(fill_level), 32'd1);

        // Vacuum stream, then flush of a 5-symbol partial word
        do_reset();
        out_ready = 1'b1;
        repeat (25) cyc(1'b1, 6'b000000, 1'b0);
        cyc(1'b0, 6'b000000, 1'b1);
        repeat (3) cyc(1'b0, 6'b000000, 1'b0);
        check("flush_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("flush_word%0d", i), got_at(i), exp2[i]);
        // Flush on an empty word is a no-op
        cyc(1'b0, 6'b000000, 1'b1);
        repeat (2) cyc(1'b0, 6'b000000, 1'b0);
        check("flush_empty_noop", 32'(got_q.size()), 32'd3);

        // Overflow: 17 words into a 16-deep FIFO
        do_reset();
        out_ready = 1'b0;
        repeat (170) cyc(1'b1, 6'b000000, 1'b0);
        check("ovf_fill", 32'(fill_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        cyc(1'b0, 6'b000000, 1'b0);
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        // Push and pop on the same edge while full
        repeat (9) cyc(1'b1, 6'b000000, 1'b0);
        out_ready = 1'b1;
        cyc(1'b1, 6'b000000, 1'b0);
        check("full_pushpop_fill", 32'(fill_level), 32'd16);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        repeat (20) cyc(1'b0, 6'b000000, 1'b0);
        check("drain_count", 32'(got_q.size()), 32'd17);
        check("drain_fill", 32'(fill_level), 32'd0);
        for (int k = 0; k < 17; k++) begin
            logic [1:0] s;
            s = (k < 16) ? 2'(k % 4) : 2'd1;
            check($sformatf("drain_word%0d", k), got_at(k), {s, 30'd0});
        end

        // Enable toggling; disabled cycles carry a multi-hot pattern that must be ignored
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cyc(1'b1, vec_tog[i/2], 1'b0);
            else            cyc(1'b0, 6'b111111, 1'b0);
        end
        check("tog_fill", 32'(fill_level), 32'd1);
        check("tog_data", out_data, 32'h1A23_58D1);

        // Asynchronous reset mid-word with 5 words buffered
        do_reset();
        out_ready = 1'b0;
        repeat (50) cyc(1'b1, 6'b000000, 1'b0);
        repeat (3) cyc(1'b1, 6'b000001, 1'b0);
        check("pre_arst_fill", 32'(fill_level), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_fill", 32'(fill_level), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) cyc(1'b1, 6'b000001, 1'b0);
        check("post_arst_fill", 32'(fill_level), 32'd1);
        check("post_arst_data", out_data, 32'h0924_9249);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
